clk_out_gen: RTL and testbench

Parametrised multi-channel clock-output generator. It takes the PLL clock domain and produces per-channel DDR data pairs (`d0`/`d1`) for output DDR registers clocked on both edges of `clk_in`, giving half-cycle resolution. Each channel has a runtime-programmable divide ratio with exact 50 % duty, including odd ratios. Enable and ratio changes are glitch-free, all channels share a common sync restart, and outputs are gated by a debounced PLL lock.

---
 rtl/clk_out_gen.sv | 121 ++++++++++++
 tb/tb_clk_out_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_out_gen.sv
// Multi-channel DDR clock-output generator with exact 50% duty.
// Glitch-free ratio/enable updates, common sync restart, debounced lock.
module clk_out_gen #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_SETTLE = 16,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              lock,
    input  logic              sync_req,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic [N_CH-1:0]   d0,
    output logic [N_CH-1:0]   d1,
    output logic [N_CH-1:0]   running,
    output logic              lock_ok
);

    localparam int LK_W = $clog2(LOCK_SETTLE + 1);
    localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_SETTLE);

    logic [LK_W-1:0]  lock_cnt;
    logic [DIV_W-1:0] div_q [N_CH];
    logic [DIV_W-1:0] cnt_q [N_CH];
    logic [DIV_W-1:0] sh_div [N_CH];
    logic [N_CH-1:0]  en_q;
    logic [N_CH-1:0]  sh_en;
    logic [N_CH-1:0]  pending;

    logic [N_CH-1:0]  run;
    logic [N_CH-1:0]  wrap;
    logic [N_CH-1:0]  apply;
    logic [N_CH-1:0]  take;
    logic [N_CH-1:0]  hi0;
    logic [N_CH-1:0]  hi1;
    logic             sync_go;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            lock_ok  <= 1'b0;
        end else if (!lock) begin
            lock_cnt <= '0;
            lock_ok  <= 1'b0;
        end else begin
            if (lock_cnt != LK_MAX)
                lock_cnt <= lock_cnt + LK_W'(1);
            lock_ok <= (lock_cnt == LK_MAX);
        end
    end

    // Out-of-range channels always look ready so the request is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++)
            if (int'(cfg_ch) == i)
                cfg_ready = !pending[i];
    end

    assign sync_go = sync_req && lock_ok;

    always_comb begin
        run   = '0;
        wrap  = '0;
        apply = '0;
        take  = '0;
        hi0   = '0;
        hi1   = '0;
        for (int i = 0; i < N_CH; i++) begin
            run[i]   = en_q[i] && (div_q[i] != '0) && lock_ok;
            wrap[i]  = run[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
            apply[i] = pending[i] && (!run[i] || wrap[i] || sync_go);
            take[i]  = cfg_valid && cfg_ready && (int'(cfg_ch) == i);
            hi0[i]   = {cnt_q[i], 1'b0} < {1'b0, div_q[i]};
            hi1[i]   = {cnt_q[i], 1'b1} < {1'b0, div_q[i]};
        end
    end

    // Pending updates land only at a period boundary, so no runt pulses.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            en_q    <= '0;
            sh_en   <= '0;
            pending <= '0;
            d0      <= '0;
            d1      <= '0;
            running <= '0;
            for (int i = 0; i < N_CH; i++) begin
                div_q[i]  <= '0;
                cnt_q[i]  <= '0;
                sh_div[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                d0[i]      <= run[i] && hi0[i];
                d1[i]      <= run[i] && hi1[i];
                running[i] <= run[i];
                if (take[i]) begin
                    sh_div[i]  <= cfg_div;
                    sh_en[i]   <= cfg_en;
                    pending[i] <= 1'b1;
                end
                if (apply[i]) begin
                    div_q[i]   <= sh_div[i];
                    en_q[i]    <= sh_en[i];
                    pending[i] <= 1'b0;
                end
                if (apply[i] || !run[i] || wrap[i] || sync_go)
                    cnt_q[i] <= '0;
                else
                    cnt_q[i] <= cnt_q[i] + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clk_out_gen.sv
// Scoreboard bench for clk_out_gen: hand-computed per-edge waveforms
// queued by the stimulus, popped and compared by a negedge monitor.
module tb_clk_out_gen;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int LS = 16;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          lock;
    logic          sync_req;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_ch;
    logic [DW-1:0] cfg_div;
    logic          cfg_en;
    logic [N-1:0]  d0;
    logic [N-1:0]  d1;
    logic [N-1:0]  running;
    logic          lock_ok;

    always #5 clk_in = ~clk_in;

    clk_out_gen #(
        .N_CH(N),
        .DIV_W(DW),
        .LOCK_SETTLE(LS)
    ) dut (
        .clk_in(clk_in),
        .rst_n(rst_n),
        .lock(lock),
        .sync_req(sync_req),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_en(cfg_en),
        .d0(d0),
        .d1(d1),
        .running(running),
        .lock_ok(lock_ok)
    );

    typedef struct {
        int         cyc;
        int         ch;
        logic [2:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic void push(int c, int ch, logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.ch  = ch;
        e.v   = v;
        sb.push_back(e);
    endfunction

    // s holds d0d1 pairs per edge, e.g. "11110000" for D=4.
    function automatic void pat(int ch, int start, int reps, string s, bit r);
        int np;
        np = s.len() / 2;
        for (int k = 0; k < reps; k++)
            for (int j = 0; j < np; j++)
                push(start + k * np + j, ch,
                     {s[2*j] == "1", s[2*j+1] == "1", r});
    endfunction

    always @(negedge clk_in) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                mon_e = sb[i];
                if (mon_e.ch < 0)
                    check($sformatf("lock_ok@%0d", cyc),
                          {7'b0, lock_ok}, {7'b0, mon_e.v[0]});
                else
                    check($sformatf("ch%0d_d0d1run@%0d", mon_e.ch, cyc),
                          {5'b0, d0[mon_e.ch], d1[mon_e.ch], running[mon_e.ch]},
                          {5'b0, mon_e.v});
                sb.delete(i);
            end
        end
    end

    task automatic to(int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic cfg(int ch, int dv, bit en);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = DW'(dv);
        cfg_en    = en;
    endtask

    task automatic rdy(string nm, bit exp);
        check(nm, {7'b0, cfg_ready}, {7'b0, exp});
    endtask

    initial begin
        rst_n     = 1'b0;
        lock      = 1'b0;
        sync_req  = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;

        to(3);
        push(3, -1, 3'b000);
        for (int c = 0; c < N; c++) push(3, c, 3'b000);
        rdy("rdy_reset", 1'b1);

        // lock first high at edge 4, ch0 D=4 accepted while unlocked
        rst_n = 1'b1;
        lock  = 1'b1;
        cfg(0, 4, 1'b1);
        push(19, -1, 3'b000);
        push(20, -1, 3'b001);
        push(20, 0, 3'b000);
        pat(0, 21, 3, "11110000", 1'b1);
        to(4);
        rdy("rdy_ch0_pending", 1'b0);
        cfg_valid = 1'b0;
        to(5);
        rdy("rdy_ch0_applied", 1'b1);

        // ch1 D=3, then D=1 at the wrap, then a stalled D=2
        to(24);
        cfg(1, 3, 1'b1);
        pat(1, 27, 2, "111000", 1'b1);
        pat(1, 33, 2, "10", 1'b1);
        pat(1, 35, 2, "1100", 1'b1);
        to(25);
        cfg_valid = 1'b0;
        rdy("rdy_ch1_idle_pend", 1'b0);
        to(26);
        rdy("rdy_ch1_idle_done", 1'b1);
        to(28);
        cfg(1, 1, 1'b1);
        to(29);
        rdy("rdy_ch1_wait0", 1'b0);
        cfg(1, 2, 1'b1);
        to(30);
        rdy("rdy_ch1_wait1", 1'b0);
        to(31);
        rdy("rdy_ch1_wait2", 1'b0);
        to(32);
        rdy("rdy_ch1_wrap", 1'b1);
        to(33);
        rdy("rdy_ch1_second", 1'b0);
        cfg_valid = 1'b0;
        to(34);
        rdy("rdy_ch1_second_done", 1'b1);

        // ch2 D=5 then disable mid-period
        to(40);
        cfg(2, 5, 1'b1);
        to(41);
        cfg_valid = 1'b0;
        pat(2, 43, 2, "1111100000", 1'b1);
        for (int e = 53; e <= 56; e++) push(e, 2, 3'b000);
        to(49);
        cfg(2, 5, 1'b0);
        to(50);
        cfg_valid = 1'b0;
        rdy("rdy_ch2_dis0", 1'b0);
        to(51);
        rdy("rdy_ch2_dis1", 1'b0);
        to(52);
        rdy("rdy_ch2_dis_done", 1'b1);

        // ch0 D=2, ch3 D=6, then sync restart
        to(56);
        cfg(0, 2, 1'b1);
        to(57);
        cfg(3, 6, 1'b1);
        pat(0, 57, 1, "11110000", 1'b1);
        pat(0, 61, 1, "110011", 1'b1);
        pat(0, 64, 6, "1100", 1'b1);
        pat(3, 60, 1, "11111100", 1'b1);
        pat(3, 64, 2, "111111000000", 1'b1);
        to(58);
        cfg_valid = 1'b0;
        to(62);
        sync_req = 1'b1;
        to(63);
        sync_req = 1'b0;

        // single-cycle lock loss
        to(76);
        lock = 1'b0;
        push(77, -1, 3'b000);
        push(93, -1, 3'b000);
        push(94, -1, 3'b001);
        push(77, 0, 3'b001);
        push(77, 3, 3'b111);
        for (int e = 78; e <= 94; e++) begin
            push(e, 0, 3'b000);
            push(e, 1, 3'b000);
            push(e, 3, 3'b000);
        end
        pat(0, 95, 2, "1100", 1'b1);
        pat(3, 95, 1, "111111000000", 1'b1);
        to(77);
        lock = 1'b1;

        // out-of-range channel is accepted and dropped
        to(101);
        cfg(5, 3, 1'b1);
        #1;
        rdy("rdy_ch5", 1'b1);
        pat(0, 102, 2, "0011", 1'b1);
        pat(1, 102, 2, "0011", 1'b1);
        pat(3, 102, 1, "11110000", 1'b1);
        for (int e = 102; e <= 106; e++) begin
            push(e, 2, 3'b000);
            push(e, 4, 3'b000);
        end
        to(102);
        cfg_valid = 1'b0;
        cfg_ch    = 3'd4;
        #1;
        rdy("rdy_ch4_after_ch5", 1'b1);

        to(110);
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL unchecked_ch%0d@%0d: got none expected %b",
                     mon_e.ch, mon_e.cyc, mon_e.v);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
